dcsk_mod: RTL and testbench

DCSK_MOD -- requirements
Module: dcsk_mod

---
 rtl/dcsk_mod_if.sv | 21 ++
 rtl/dcsk_mod.sv | 107 ++++++++++
 tb/tb_dcsk_mod.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dcsk_mod_if.sv
// rtl/dcsk_mod_if.sv - payload handshake and serial chip stream bundle for dcsk_mod
interface dcsk_mod_if;
  logic [31:0] In_Data;
  logic        In_Valid;
  logic        In_Ready;
  logic [1:0]  Spread_Factor_Sel;
  logic        Out_Mod_Data;
  logic        Out_Valid;
  logic        Busy;
  logic        Frame_Done;

  modport master (
    output In_Data, In_Valid, Spread_Factor_Sel,
    input  In_Ready, Out_Mod_Data, Out_Valid, Busy, Frame_Done
  );

  modport slave (
    input  In_Data, In_Valid, Spread_Factor_Sel,
    output In_Ready, Out_Mod_Data, Out_Valid, Busy, Frame_Done
  );
endinterface

// File: rtl/dcsk_mod.sv
// rtl/dcsk_mod.sv - DCSK modulator: 32-bit frame, per bit an LFSR reference half then
// a data half that repeats (bit 1) or inverts (bit 0) the reference chips.
module dcsk_mod (
  input  logic      Clk,
  input  logic      N_Rst,
  dcsk_mod_if.slave bus
);
  typedef enum logic [1:0] {IDLE, REF, DATA, DONE} state_t;

  state_t      state;
  logic [7:0]  lfsr;
  logic [3:0]  chip;
  logic [4:0]  bit_idx;
  logic [31:0] data;
  logic [1:0]  sf_sel;
  logic [15:0] ref_buf;

  logic [7:0]  lfsr_adv;
  logic [3:0]  chip_last;
  logic [3:0]  chip_inc;
  logic        last_chip;
  logic        cur_bit;

  assign lfsr_adv  = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[4], lfsr[7:1]};
  assign chip_inc  = chip + 4'd1;
  assign last_chip = (chip == chip_last);
  assign cur_bit   = data[bit_idx];

  always_comb begin
    case (sf_sel)
      2'd0:    chip_last = 4'd1;
      2'd1:    chip_last = 4'd3;
      2'd2:    chip_last = 4'd7;
      default: chip_last = 4'd15;
    endcase
  end

  // Outputs are registered, so each branch loads the chip for the state being entered.
  always_ff @(posedge Clk or negedge N_Rst) begin
    if (!N_Rst) begin
      state            <= IDLE;
      lfsr             <= 8'hA5;
      chip             <= 4'd0;
      bit_idx          <= 5'd0;
      data             <= 32'd0;
      sf_sel           <= 2'd0;
      ref_buf          <= 16'd0;
      bus.In_Ready     <= 1'b1;
      bus.Out_Mod_Data <= 1'b0;
      bus.Out_Valid    <= 1'b0;
      bus.Busy         <= 1'b0;
      bus.Frame_Done   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.In_Valid && bus.In_Ready) begin
            data             <= bus.In_Data;
            sf_sel           <= bus.Spread_Factor_Sel;
            chip             <= 4'd0;
            bit_idx          <= 5'd0;
            state            <= REF;
            bus.In_Ready     <= 1'b0;
            bus.Out_Valid    <= 1'b1;
            bus.Busy         <= 1'b1;
            bus.Out_Mod_Data <= lfsr[0];
          end
        end
        REF: begin
          ref_buf[chip] <= lfsr[0];
          lfsr          <= lfsr_adv;
          if (last_chip) begin
            chip             <= 4'd0;
            state            <= DATA;
            bus.Out_Mod_Data <= ~(ref_buf[0] ^ cur_bit);
          end else begin
            chip             <= chip_inc;
            bus.Out_Mod_Data <= lfsr_adv[0];
          end
        end
        DATA: begin
          if (last_chip) begin
            chip <= 4'd0;
            if (bit_idx == 5'd31) begin
              state            <= DONE;
              bus.Out_Valid    <= 1'b0;
              bus.Busy         <= 1'b0;
              bus.Out_Mod_Data <= 1'b0;
              bus.Frame_Done   <= 1'b1;
            end else begin
              bit_idx          <= bit_idx + 5'd1;
              state            <= REF;
              bus.Out_Mod_Data <= lfsr[0];
            end
          end else begin
            chip             <= chip_inc;
            bus.Out_Mod_Data <= ~(ref_buf[chip_inc] ^ cur_bit);
          end
        end
        default: begin
          state          <= IDLE;
          bus.Frame_Done <= 1'b0;
          bus.In_Ready   <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_dcsk_mod.sv
// tb/tb_dcsk_mod.sv - self-checking bench for dcsk_mod: per-cycle frame model,
// loopback demodulation and hand-computed chip literals.
module tb_dcsk_mod;
  logic Clk;
  logic N_Rst;
  dcsk_mod_if bus ();

  dcsk_mod dut (.Clk(Clk), .N_Rst(N_Rst), .bus(bus.slave));

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct packed {
    logic valid;
    logic chip;
    logic done;
  } exp_t;

  int   errors = 0;
  int   checks = 0;
  exp_t expq[$];
  logic [7:0] m_lfsr = 8'hA5;

  int cyc = 0;
  int cur_len = 0;
  int last_len = 0;
  int done_cnt = 0;
  int last_valid_cyc = 0;
  int last_gap = 0;
  bit obs[$];
  bit last_obs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected cycle stream of one frame: reference half from the LFSR, data half copied or inverted.
  task automatic push_frame(input logic [31:0] d, input logic [1:0] s);
    int  sf;
    bit  r[16];
    exp_t e;
    sf = 2 << s;
    for (int b = 0; b < 32; b++) begin
      for (int k = 0; k < sf; k++) begin
        r[k]   = m_lfsr[0];
        m_lfsr = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[4], m_lfsr[7:1]};
        e = '{valid: 1'b1, chip: r[k], done: 1'b0};
        expq.push_back(e);
      end
      for (int k = 0; k < sf; k++) begin
        e = '{valid: 1'b1, chip: d[b] ? r[k] : ~r[k], done: 1'b0};
        expq.push_back(e);
      end
    end
    e = '{valid: 1'b0, chip: 1'b0, done: 1'b1};
    expq.push_back(e);
  endtask

  always @(negedge Clk) begin
    exp_t e;
    bit   popped;
    cyc++;
    if (!N_Rst) begin
      chk("rst_valid", bus.Out_Valid, 0);
      chk("rst_chip", bus.Out_Mod_Data, 0);
      chk("rst_busy", bus.Busy, 0);
      chk("rst_done", bus.Frame_Done, 0);
      expq.delete();
      m_lfsr  = 8'hA5;
      cur_len = 0;
      obs.delete();
    end else begin
      popped = 1'b0;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        popped = 1'b1;
        chk("valid", bus.Out_Valid, e.valid);
        chk("chip", bus.Out_Mod_Data, e.chip);
        chk("busy", bus.Busy, e.valid);
        chk("frame_done", bus.Frame_Done, e.done);
        chk("ready_busy", bus.In_Ready, 0);
      end else begin
        chk("idle_valid", bus.Out_Valid, 0);
        chk("idle_chip", bus.Out_Mod_Data, 0);
        chk("idle_busy", bus.Busy, 0);
        chk("idle_done", bus.Frame_Done, 0);
        chk("idle_ready", bus.In_Ready, 1);
      end
      if (!popped && bus.In_Valid)
        push_frame(bus.In_Data, bus.Spread_Factor_Sel);

      if (bus.Out_Valid) begin
        if (cur_len == 0) last_gap = cyc - last_valid_cyc;
        obs.push_back(bus.Out_Mod_Data);
        cur_len++;
        last_valid_cyc = cyc;
      end
      if (bus.Frame_Done) begin
        chk("done_after_last", cyc - last_valid_cyc, 1);
        last_len = cur_len;
        last_obs = obs;
        cur_len  = 0;
        obs.delete();
        done_cnt++;
      end
    end
  end

  function automatic logic [31:0] demod(input int sf);
    logic [31:0] w;
    w = '0;
    if (last_obs.size() >= 64 * sf)
      for (int b = 0; b < 32; b++)
        w[b] = (last_obs[2*sf*b] == last_obs[2*sf*b + sf]);
    return w;
  endfunction

  function automatic logic [7:0] first_chips(input int n);
    logic [7:0] v;
    v = '0;
    for (int i = 0; i < n; i++)
      if (i < last_obs.size()) v = {v[6:0], last_obs[i]};
    return v;
  endfunction

  task automatic wait_done(input int budget);
    int d0;
    int n;
    d0 = done_cnt;
    n  = 0;
    while (done_cnt == d0 && n < budget) begin
      @(negedge Clk);
      #1;
      n++;
    end
    if (done_cnt == d0) begin
      checks++;
      errors++;
      $display("FAIL wait_done: no Frame_Done within %0d cycles", budget);
    end
  endtask

  task automatic send(input logic [31:0] d, input logic [1:0] s);
    @(posedge Clk);
    #2;
    bus.In_Data = d;
    bus.Spread_Factor_Sel = s;
    bus.In_Valid = 1'b1;
    @(posedge Clk);
    #2;
    bus.In_Valid = 1'b0;
  endtask

  initial begin
    logic [31:0] w;
    int          mism;
    int          dsave;
    int          n;

    N_Rst = 1'b0;
    bus.In_Data = 32'd0;
    bus.In_Valid = 1'b0;
    bus.Spread_Factor_Sel = 2'd0;
    #12;
    chk("reset_valid", bus.Out_Valid, 0);
    chk("reset_done", bus.Frame_Done, 0);
    @(posedge Clk);
    #2;
    N_Rst = 1'b1;
    @(negedge Clk);
    #1;
    chk("ready_after_reset", bus.In_Ready, 1);

    // Reference vector from seed A5 with SF=2.
    send(32'h0000_0001, 2'd0);
    wait_done(500);
    chk("sf2_len", last_len, 128);
    chk("sf2_first8", first_chips(8), 8'b1010_1001);
    chk("sf2_demod", demod(2), 32'h0000_0001);

    // SF=16 all ones: each data half repeats its reference half.
    send(32'hFFFF_FFFF, 2'd3);
    wait_done(2000);
    chk("sf16_len", last_len, 1024);
    mism = 0;
    for (int b = 0; b < 32; b++)
      for (int k = 0; k < 16; k++)
        if (last_obs.size() == 1024 && last_obs[32*b + k] != last_obs[32*b + 16 + k]) mism++;
    chk("sf16_halves_equal", mism, 0);

    // Loopback with random words at the remaining spread factors.
    for (int s = 0; s < 3; s++) begin
      w = $urandom;
      send(w, 2'(s));
      wait_done(1200);
      chk("loop_len", last_len, 64 * (2 << s));
      chk("loop_demod", demod(2 << s), w);
    end

    // In_Valid held high: mid-frame data changes ignored, one idle-ready cycle between frames.
    @(posedge Clk);
    #2;
    bus.In_Data = 32'h5A5A_3C3C;
    bus.Spread_Factor_Sel = 2'd1;
    bus.In_Valid = 1'b1;
    repeat (40) @(posedge Clk);
    #2;
    bus.In_Data = 32'hDEAD_BEEF;
    wait_done(600);
    chk("hold_f1_demod", demod(4), 32'h5A5A_3C3C);
    bus.In_Data = 32'h9876_5432;
    repeat (20) @(posedge Clk);
    #2;
    bus.In_Data = 32'h1234_5678;
    wait_done(600);
    bus.In_Valid = 1'b0;
    chk("hold_f2_demod", demod(4), 32'h9876_5432);
    chk("hold_f2_len", last_len, 256);
    chk("hold_gap", last_gap, 3);

    // Reset at chip 50 of an SF=4 frame.
    send(32'hC3A5_0F1E, 2'd1);
    n = 0;
    while (cur_len < 50 && n < 1000) begin
      @(negedge Clk);
      #1;
      n++;
    end
    chk("abort_reached_chip50", cur_len, 50);
    dsave = done_cnt;
    N_Rst = 1'b0;
    #1;
    chk("abort_valid_async", bus.Out_Valid, 0);
    chk("abort_busy_async", bus.Busy, 0);
    repeat (3) @(posedge Clk);
    #2;
    N_Rst = 1'b1;
    repeat (5) @(posedge Clk);
    chk("abort_no_done", done_cnt, dsave);
    send(32'h0F0F_1234, 2'd1);
    wait_done(600);
    chk("abort_next_first4", first_chips(4), 8'b0000_1010);
    chk("abort_next_demod", demod(4), 32'h0F0F_1234);

    // Spread factor select changed mid-frame only affects the next frame.
    send(32'h8000_0003, 2'd0);
    repeat (30) @(posedge Clk);
    #2;
    bus.Spread_Factor_Sel = 2'd2;
    wait_done(500);
    chk("sel_change_len_cur", last_len, 128);
    chk("sel_change_demod_cur", demod(2), 32'h8000_0003);
    send(32'h7E81_00FF, bus.Spread_Factor_Sel);
    wait_done(1200);
    chk("sel_change_len_next", last_len, 512);
    chk("sel_change_demod_next", demod(8), 32'h7E81_00FF);

    repeat (3) @(posedge Clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
